// File: rtl/marquee_scan_ctrl.sv
// Scan and scroll controller for the 16-segment marquee: walks a message buffer
// through one shared char ROM, one digit slot at a time, and scrolls left every STEP_FRAMES scans.
module marquee_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int MSG_DEPTH   = 32,
  parameter int SCAN_DIV    = 1000,
  parameter int GUARD_CYC   = 16,
  parameter int STEP_FRAMES = 50,
  localparam int AW = $clog2(MSG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [AW:0]       msg_len,
  input  logic              run,
  output logic [7:0]        ascii,
  output logic [DIGITS-1:0] digit_en,
  output logic              busy,
  output logic              step
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(STEP_FRAMES + 1);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(STEP_FRAMES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     head_q, head_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [AW:0]       len_q, len_d;
  logic [7:0]        ascii_q, ascii_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic              step_q, step_d;
  logic              load;
  logic [AW-1:0]     head_adv;

  logic [7:0] mem_q [MSG_DEPTH];

  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    if (l > (AW+1)'(MSG_DEPTH)) return (AW+1)'(MSG_DEPTH);
    return l;
  endfunction

  // Wraps on anything at or past the last message entry, so a stale pointer can never escape.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p, input logic [AW:0] l);
    if (l == '0 || {1'b0, p} >= l - 1'b1) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    rd_ptr_d   = rd_ptr_q;
    head_d     = head_q;
    frame_d    = frame_q;
    len_d      = len_q;
    ascii_d    = ascii_q;
    digit_en_d = digit_en_q;
    step_d     = 1'b0;
    load       = 1'b0;
    head_adv   = next_ptr(head_q, len_q);
    case (state_q)
      ST_IDLE: begin
        ascii_d    = 8'h00;
        digit_en_d = '0;
        if (run) begin
          state_d = ST_GUARD;
          len_d   = clamp_len(msg_len);
          // A retained head outside a shorter new message restarts from the first character.
          head_d   = ({1'b0, head_q} >= len_d) ? '0 : head_q;
          rd_ptr_d = head_d;
          digit_d  = '0;
          cnt_d    = '0;
          load     = 1'b1;
        end
      end
      ST_GUARD: begin
        if (!run) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          ascii_d    = 8'h00;
          digit_en_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GUARD_LAST) begin
            state_d    = ST_SHOW;
            digit_en_d = DIGITS'(1) << digit_q;
          end
        end
      end
      ST_SHOW: begin
        if (!run) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          ascii_d    = 8'h00;
          digit_en_d = '0;
        end else if (cnt_q == SLOT_LAST) begin
          state_d    = ST_GUARD;
          cnt_d      = '0;
          digit_en_d = '0;
          load       = 1'b1;
          if (digit_q != DIGIT_LAST) begin
            digit_d  = digit_q + 1'b1;
            rd_ptr_d = next_ptr(rd_ptr_q, len_q);
          end else begin
            digit_d = '0;
            if (frame_q == FRAME_LAST) begin
              frame_d  = '0;
              head_d   = head_adv;
              rd_ptr_d = head_adv;
              step_d   = 1'b1;
            end else begin
              frame_d  = frame_q + 1'b1;
              rd_ptr_d = head_q;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        ascii_d    = 8'h00;
        digit_en_d = '0;
      end
    endcase
    // The slot character is fetched once at GUARD entry, from the already-advanced pointer.
    if (load) ascii_d = (len_d == '0) ? 8'h00 : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      digit_q    <= '0;
      rd_ptr_q   <= '0;
      head_q     <= '0;
      frame_q    <= '0;
      len_q      <= '0;
      ascii_q    <= 8'h00;
      digit_en_q <= '0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      rd_ptr_q   <= rd_ptr_d;
      head_q     <= head_d;
      frame_q    <= frame_d;
      len_q      <= len_d;
      ascii_q    <= ascii_d;
      digit_en_q <= digit_en_d;
      step_q     <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign ascii    = ascii_q;
  assign digit_en = digit_en_q;
  assign busy     = (state_q != ST_IDLE);
  assign step     = step_q;

endmodule

// File: tb/tb_marquee_scan_ctrl.sv
// Directed bench for marquee_scan_ctrl: scan timing, scrolling, wrap, writes, run/stop and reset.
module tb_marquee_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic [AW:0]       msg_len = '0;
  logic              run = 1'b0;
  logic [7:0]        ascii;
  logic [DIGITS-1:0] digit_en;
  logic              busy;
  logic              step;

  int n_checks = 0;
  int n_fail   = 0;

  marquee_scan_ctrl #(
    .DIGITS(4), .MSG_DEPTH(16), .SCAN_DIV(8), .GUARD_CYC(2), .STEP_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .run(run), .ascii(ascii), .digit_en(digit_en), .busy(busy), .step(step)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk_eq({tag, " busy"}, 32'(busy), 32'd0);
    chk_eq({tag, " den"}, 32'(digit_en), 32'd0);
    chk_eq({tag, " ascii"}, 32'(ascii), 32'd0);
    chk_eq({tag, " step"}, 32'(step), 32'd0);
  endtask

  // Entered one time unit after the edge that starts the first GUARD cycle of a frame.
  task automatic check_frame(input string tag, input logic [31:0] chars, input int exp_step,
                             input bit do_wr, input logic [AW-1:0] wa, input logic [7:0] wd);
    logic [7:0] c;
    for (int d = 0; d < DIGITS; d++) begin
      c = chars[31-8*d -: 8];
      chk_eq($sformatf("%s d%0d ascii", tag, d), 32'(ascii), 32'(c));
      chk_eq($sformatf("%s d%0d guard den", tag, d), 32'(digit_en), 32'd0);
      chk_eq($sformatf("%s d%0d busy", tag, d), 32'(busy), 32'd1);
      if (d == 0 && exp_step >= 0) chk_eq($sformatf("%s step", tag), 32'(step), 32'(exp_step));
      if (d == 0 && do_wr) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        tick(1);
        wr_en = 1'b0;
        chk_eq($sformatf("%s d%0d guard2 den", tag, d), 32'(digit_en), 32'd0);
        tick(1);
      end else begin
        tick(1);
        chk_eq($sformatf("%s d%0d guard2 den", tag, d), 32'(digit_en), 32'd0);
        tick(1);
      end
      chk_eq($sformatf("%s d%0d show den", tag, d), 32'(digit_en), 32'(1 << d));
      chk_eq($sformatf("%s d%0d show step", tag, d), 32'(step), 32'd0);
      tick(5);
      chk_eq($sformatf("%s d%0d last den", tag, d), 32'(digit_en), 32'(1 << d));
      chk_eq($sformatf("%s d%0d last ascii", tag, d), 32'(ascii), 32'(c));
      tick(1);
    end
  endtask

  initial begin
    // Reset and idle behaviour
    tick(3);
    chk_idle("rst");
    rst_n = 1'b1;
    tick(4);
    chk_idle("idle");

    wr(0, "H"); wr(1, "E"); wr(2, "L"); wr(3, "L"); wr(4, "O");
    msg_len = 5'd5;
    run = 1'b1;
    tick(1);
    chk_eq("start busy", 32'(busy), 32'd1);

    // Scroll through every head position of "HELLO" and back to the start
    check_frame("f0", "HELL", 0, 0, 0, 0);
    check_frame("f1", "HELL", 0, 0, 0, 0);
    check_frame("f2", "ELLO", 1, 0, 0, 0);
    check_frame("f3", "ELLO", 0, 0, 0, 0);
    check_frame("f4", "LLOH", 1, 0, 0, 0);
    check_frame("f5", "LLOH", 0, 0, 0, 0);
    check_frame("f6", "LOHE", 1, 0, 0, 0);
    check_frame("f7", "LOHE", 0, 0, 0, 0);
    check_frame("f8", "OHEL", 1, 0, 0, 0);
    check_frame("f9", "OHEL", 0, 0, 0, 0);
    check_frame("f10", "HELL", 1, 0, 0, 0);

    // Write during slot 0 shows up in slot 1; msg_len change while busy is ignored
    check_frame("f11", "HZLL", 0, 1, 4'd1, "Z");
    msg_len = 5'd3;
    check_frame("f12", "ZLLO", 1, 0, 0, 0);
    check_frame("f13", "ZLLO", 0, 0, 0, 0);
    check_frame("f14", "LLOH", 1, 0, 0, 0);

    chk_eq("f15 step", 32'(step), 32'd0);
    chk_eq("f15 ascii", 32'(ascii), 32'("L"));
    tick(18);
    chk_eq("f15 d2 den", 32'(digit_en), 32'b0100);
    chk_eq("f15 d2 ascii", 32'(ascii), 32'("O"));
    run = 1'b0;
    tick(1);
    chk_idle("stop");
    tick(2);
    chk_idle("stop hold");

    // Resume: head 2 and frame count 1 retained, new length 3 latched
    run = 1'b1;
    tick(1);
    check_frame("r0", "LHZL", 0, 0, 0, 0);
    check_frame("r1", "HZLH", 1, 0, 0, 0);
    run = 1'b0;
    tick(1);
    chk_idle("stop2");

    // Two-character message repeats across digits
    wr(0, "A"); wr(1, "B");
    msg_len = 5'd2;
    run = 1'b1;
    tick(1);
    check_frame("ab0", "ABAB", 0, 0, 0, 0);
    check_frame("ab1", "BABA", 1, 0, 0, 0);
    check_frame("ab2", "BABA", 0, 0, 0, 0);
    run = 1'b0;
    tick(1);
    chk_idle("stop3");

    // Empty message blanks every slot
    msg_len = 5'd0;
    run = 1'b1;
    tick(1);
    check_frame("z0", 32'h0, 0, 0, 0, 0);
    check_frame("z1", 32'h0, -1, 0, 0, 0);
    run = 1'b0;
    tick(1);
    chk_idle("stop4");

    // Oversized length clamps to the buffer depth
    msg_len = 5'd31;
    run = 1'b1;
    tick(1);
    chk_eq("clamp ascii", 32'(ascii), 32'("A"));
    run = 1'b0;
    tick(1);

    // Asynchronous reset in the middle of a SHOW slot
    msg_len = 5'd2;
    run = 1'b1;
    tick(1);
    tick(3);
    chk_eq("pre-rst den", 32'(digit_en), 32'd1);
    chk_eq("pre-rst ascii", 32'(ascii), 32'("A"));
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async rst");
    tick(1);
    run = 1'b0;
    rst_n = 1'b1;
    tick(3);
    chk_idle("post rst");
    run = 1'b1;
    tick(1);
    check_frame("pr0", "ABAB", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
